// File: rtl/irq_pending_arbiter8_if.sv
// Request/grant bundle between raw request sources, the arbiter and the id consumer.
// master = sources plus consumer side, slave = arbiter side.
interface irq_pending_arbiter8_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] pending;

    modport master (
        output req,
        output mask,
        output ack,
        input  irq_valid,
        input  irq_id,
        input  pending
    );

    modport slave (
        input  req,
        input  mask,
        input  ack,
        output irq_valid,
        output irq_id,
        output pending
    );
endinterface

// File: rtl/irq_pending_arbiter8.sv
// Pending-capture plus fixed-priority (bit 7 high) arbiter: 2 cycles from req to irq_valid.
// The presented id is held until ack or the optional timeout, then irq_valid stays low for one cycle.
module irq_pending_arbiter8 #(
    parameter bit          EDGE_MODE   = 1'b1,
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    irq_pending_arbiter8_if.slave  bus
);
    typedef enum logic {IDLE, PRESENT} state_t;

    localparam logic [7:0] TO_LAST = (ACK_TIMEOUT == 0) ? 8'd0 : 8'(ACK_TIMEOUT - 1);

    state_t     state;
    logic [7:0] req_d;
    logic [7:0] pending_q;
    logic       valid_q;
    logic [2:0] id_q;
    logic [7:0] cnt;

    logic [7:0] set_vec;
    logic [7:0] clr_vec;
    logic [7:0] cand;
    logic [2:0] win_id;

    function automatic logic [2:0] hi_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    always_comb begin
        set_vec = EDGE_MODE ? (bus.req & ~req_d) : bus.req;
        clr_vec = 8'd0;
        if (state == PRESENT && bus.ack) clr_vec = 8'd1 << id_q;
        cand    = pending_q & ~bus.mask;
        win_id  = hi_idx(cand);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Loading req (not 0) keeps a line held through reset from looking like an edge.
            req_d     <= bus.req;
            pending_q <= 8'd0;
            valid_q   <= 1'b0;
            id_q      <= 3'd0;
            cnt       <= 8'd0;
            state     <= IDLE;
        end else begin
            req_d     <= bus.req;
            pending_q <= (pending_q & ~clr_vec) | set_vec;
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (cand != 8'd0) begin
                        id_q    <= win_id;
                        valid_q <= 1'b1;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.ack) begin
                        valid_q <= 1'b0;
                        cnt     <= 8'd0;
                        state   <= IDLE;
                    end else if (ACK_TIMEOUT != 0 && cnt == TO_LAST) begin
                        // Pending bit is kept so the source is arbitrated again.
                        valid_q <= 1'b0;
                        cnt     <= 8'd0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq_valid = valid_q;
    assign bus.irq_id    = id_q;
    assign bus.pending   = pending_q;
endmodule

// File: tb/tb_irq_pending_arbiter8.sv
// Directed bench: edge-mode, timeout and level-mode instances share clk and rst.
module tb_irq_pending_arbiter8;
    logic clk;
    logic rst;
    int   total;
    int   passed;

    irq_pending_arbiter8_if b0 ();
    irq_pending_arbiter8_if b1 ();
    irq_pending_arbiter8_if b2 ();

    irq_pending_arbiter8 #(.EDGE_MODE(1'b1), .ACK_TIMEOUT(0)) u_edge (.clk(clk), .rst(rst), .bus(b0));
    irq_pending_arbiter8 #(.EDGE_MODE(1'b1), .ACK_TIMEOUT(4)) u_to   (.clk(clk), .rst(rst), .bus(b1));
    irq_pending_arbiter8 #(.EDGE_MODE(1'b0), .ACK_TIMEOUT(0)) u_lvl  (.clk(clk), .rst(rst), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b0.req = 8'h00; b0.mask = 8'h00; b0.ack = 1'b0;
        b1.req = 8'h00; b1.mask = 8'h00; b1.ack = 1'b0;
        b2.req = 8'h00; b2.mask = 8'h00; b2.ack = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({b0.irq_valid, b0.irq_id, b0.pending} !== 12'h000)
            $display("FAIL reset_edge: got v=%0b id=%0d pend=%h want 0", b0.irq_valid, b0.irq_id, b0.pending);
        else passed++;
        total++;
        if ({b1.irq_valid, b1.irq_id, b1.pending, b2.irq_valid, b2.irq_id, b2.pending} !== 24'h0)
            $display("FAIL reset_others: got to_pend=%h lvl_pend=%h want 0", b1.pending, b2.pending);
        else passed++;
    endtask

    task automatic test_edge_latency();
        apply_reset();
        b0.req = 8'h10;
        tick();
        b0.req = 8'h00;
        total++;
        if (b0.pending !== 8'h10 || b0.irq_valid !== 1'b0)
            $display("FAIL edge_capture: got pend=%h v=%0b want pend=10 v=0", b0.pending, b0.irq_valid);
        else passed++;
        tick();
        total++;
        if (b0.irq_valid !== 1'b1 || b0.irq_id !== 3'd4)
            $display("FAIL edge_present: got v=%0b id=%0d want v=1 id=4", b0.irq_valid, b0.irq_id);
        else passed++;
        b0.ack = 1'b1;
        tick();
        b0.ack = 1'b0;
        total++;
        if (b0.irq_valid !== 1'b0 || b0.pending !== 8'h00)
            $display("FAIL edge_ack: got v=%0b pend=%h want v=0 pend=00", b0.irq_valid, b0.pending);
        else passed++;
        tick();
        total++;
        if (b0.irq_valid !== 1'b0)
            $display("FAIL edge_idle_after_ack: got v=%0b want 0", b0.irq_valid);
        else passed++;
    endtask

    task automatic test_priority();
        logic [2:0] exp_id [3];
        exp_id[0] = 3'd7; exp_id[1] = 3'd2; exp_id[2] = 3'd0;
        apply_reset();
        b0.req = 8'h85;
        tick();
        b0.req = 8'h00;
        tick();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (b0.irq_valid !== 1'b1 || b0.irq_id !== exp_id[k])
                $display("FAIL prio_grant%0d: got v=%0b id=%0d want v=1 id=%0d", k, b0.irq_valid, b0.irq_id, exp_id[k]);
            else passed++;
            b0.ack = 1'b1;
            tick();
            b0.ack = 1'b0;
            total++;
            if (b0.irq_valid !== 1'b0)
                $display("FAIL prio_gap%0d: got v=%0b want 0", k, b0.irq_valid);
            else passed++;
            tick();
        end
        total++;
        if (b0.pending !== 8'h00 || b0.irq_valid !== 1'b0)
            $display("FAIL prio_drained: got pend=%h v=%0b want 00 v=0", b0.pending, b0.irq_valid);
        else passed++;
    endtask

    task automatic test_mask_no_preempt();
        apply_reset();
        b0.mask = 8'h80;
        b0.req  = 8'h82;
        tick();
        b0.req = 8'h00;
        tick();
        total++;
        if (b0.irq_valid !== 1'b1 || b0.irq_id !== 3'd1)
            $display("FAIL mask_first: got v=%0b id=%0d want v=1 id=1", b0.irq_valid, b0.irq_id);
        else passed++;
        b0.req  = 8'h40;
        b0.mask = 8'h82;
        tick();
        b0.req = 8'h00;
        tick();
        total++;
        if (b0.irq_valid !== 1'b1 || b0.irq_id !== 3'd1 || b0.pending !== 8'hC2)
            $display("FAIL mask_hold: got v=%0b id=%0d pend=%h want v=1 id=1 pend=c2", b0.irq_valid, b0.irq_id, b0.pending);
        else passed++;
        b0.ack = 1'b1;
        tick();
        b0.ack = 1'b0;
        tick();
        total++;
        if (b0.irq_valid !== 1'b1 || b0.irq_id !== 3'd6 || b0.pending !== 8'hC0)
            $display("FAIL mask_next: got v=%0b id=%0d pend=%h want v=1 id=6 pend=c0", b0.irq_valid, b0.irq_id, b0.pending);
        else passed++;
        b0.ack = 1'b1;
        tick();
        b0.ack = 1'b0;
        tick();
        total++;
        if (b0.pending !== 8'h80 || b0.irq_valid !== 1'b0)
            $display("FAIL mask_keep7: got pend=%h v=%0b want pend=80 v=0", b0.pending, b0.irq_valid);
        else passed++;
    endtask

    task automatic test_set_clear();
        apply_reset();
        b0.req = 8'h08;
        tick();
        b0.req = 8'h00;
        tick();
        b0.req = 8'h08;
        b0.ack = 1'b1;
        tick();
        b0.req = 8'h00;
        b0.ack = 1'b0;
        total++;
        if (b0.pending !== 8'h08 || b0.irq_valid !== 1'b0)
            $display("FAIL setclr_keep: got pend=%h v=%0b want pend=08 v=0", b0.pending, b0.irq_valid);
        else passed++;
        tick();
        total++;
        if (b0.irq_valid !== 1'b1 || b0.irq_id !== 3'd3)
            $display("FAIL setclr_repeat: got v=%0b id=%0d want v=1 id=3", b0.irq_valid, b0.irq_id);
        else passed++;
    endtask

    task automatic test_timeout();
        apply_reset();
        b1.req = 8'h20;
        tick();
        b1.req = 8'h00;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (b1.irq_valid !== 1'b1 || b1.irq_id !== 3'd5)
                $display("FAIL timeout_high%0d: got v=%0b id=%0d want v=1 id=5", c, b1.irq_valid, b1.irq_id);
            else passed++;
        end
        tick();
        total++;
        if (b1.irq_valid !== 1'b0 || b1.pending !== 8'h20)
            $display("FAIL timeout_drop: got v=%0b pend=%h want v=0 pend=20", b1.irq_valid, b1.pending);
        else passed++;
        tick();
        total++;
        if (b1.irq_valid !== 1'b1 || b1.irq_id !== 3'd5 || b1.pending !== 8'h20)
            $display("FAIL timeout_rearb: got v=%0b id=%0d pend=%h want v=1 id=5 pend=20", b1.irq_valid, b1.irq_id, b1.pending);
        else passed++;
    endtask

    task automatic test_level_and_reset();
        apply_reset();
        b2.req = 8'h01;
        tick();
        total++;
        if (b2.pending !== 8'h01)
            $display("FAIL level_capture: got pend=%h want 01", b2.pending);
        else passed++;
        tick();
        total++;
        if (b2.irq_valid !== 1'b1 || b2.irq_id !== 3'd0)
            $display("FAIL level_present: got v=%0b id=%0d want v=1 id=0", b2.irq_valid, b2.irq_id);
        else passed++;
        b2.ack = 1'b1;
        tick();
        b2.ack = 1'b0;
        total++;
        if (b2.irq_valid !== 1'b0 || b2.pending !== 8'h01)
            $display("FAIL level_repend: got v=%0b pend=%h want v=0 pend=01", b2.irq_valid, b2.pending);
        else passed++;
        tick();
        total++;
        if (b2.irq_valid !== 1'b1 || b2.irq_id !== 3'd0)
            $display("FAIL level_again: got v=%0b id=%0d want v=1 id=0", b2.irq_valid, b2.irq_id);
        else passed++;
        rst = 1'b1;
        tick();
        total++;
        if ({b2.irq_valid, b2.irq_id, b2.pending} !== 12'h000)
            $display("FAIL level_midreset: got v=%0b id=%0d pend=%h want all 0", b2.irq_valid, b2.irq_id, b2.pending);
        else passed++;
        rst = 1'b0;
        b2.req = 8'h00;
    endtask

    task automatic test_edge_held_reset();
        idle_inputs();
        b0.req = 8'h01;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        total++;
        if (b0.pending !== 8'h00 || b0.irq_valid !== 1'b0)
            $display("FAIL edge_held_reset: got pend=%h v=%0b want pend=00 v=0", b0.pending, b0.irq_valid);
        else passed++;
        b0.req = 8'h00;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_edge_latency();
        test_priority();
        test_mask_no_preempt();
        test_set_clear();
        test_timeout();
        test_level_and_reset();
        test_edge_held_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
